// File: rtl/arm_data_mem_bridge.sv
// Purpose  : data-side memory stage for the single-cycle ARM core. It holds a word RAM,
//            a posted-write VRAM window that feeds a FIFO, and a read-only FIFO status register.
// Latency  : loads are combinational in the same cycle. A VRAM store at edge N is visible on vram_* in cycle N+1.
// Backpress: the FIFO head holds while vram_ready=0. A store into a full FIFO with no pop is dropped and sets sticky overflow.
// Ports    : clk/reset (async, active-high); MemWrite, ALUResult (byte address), WriteData -> ReadData;
//            vram_valid/vram_ready/vram_addr/vram_data carry the drained VRAM writes.
module arm_data_mem_bridge #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int VRAM_AW    = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemWrite,
    input  logic [31:0]        ALUResult,
    input  logic [31:0]        WriteData,
    output logic [31:0]        ReadData,
    output logic               vram_valid,
    input  logic               vram_ready,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [31:0]        vram_data
);
    localparam int RW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] REG_RAM    = 4'h0;
    localparam logic [3:0] REG_VRAM   = 4'h1;
    localparam logic [3:0] REG_STATUS = 4'h2;

    logic [31:0]        r_mem       [RAM_WORDS];
    logic [VRAM_AW-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;

    logic [3:0]         w_region;
    logic [RW-1:0]      w_ram_idx;
    logic [VRAM_AW-1:0] w_vaddr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_push_acc;
    logic               w_push_rej;
    logic               w_ovf_clr;
    logic               w_unused_addr_bits;

    assign w_region  = ALUResult[31:28];
    assign w_ram_idx = ALUResult[RW+1:2];
    assign w_vaddr   = ALUResult[VRAM_AW+1:2];

    // The byte-lane bits and the bits above each region's index alias. They are deliberately unused.
    assign w_unused_addr_bits = ^ALUResult[27:0];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_push     = MemWrite && (w_region == REG_VRAM);
    assign w_pop      = !w_empty && vram_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_acc = w_push && (!w_full || w_pop);
    assign w_push_rej = w_push && w_full && !w_pop;
    assign w_ovf_clr  = MemWrite && (w_region == REG_STATUS) && WriteData[31];

    // The RAM is not reset, so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (MemWrite && (w_region == REG_RAM)) begin
            r_mem[w_ram_idx] <= WriteData;
        end
    end

    // FIFO storage is not reset either. The head is masked on the outputs while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_fifo_addr[r_wr_ptr] <= w_vaddr;
            r_fifo_data[r_wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // If a clear arrives on the same edge as a drop, the set takes priority.
            if (w_push_rej)     r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;
        end
    end

    assign vram_valid = !w_empty;
    assign vram_addr  = w_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign vram_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr];

    always_comb begin
        ReadData = 32'h0;
        case (w_region)
            REG_RAM:    ReadData = r_mem[w_ram_idx];
            REG_STATUS: ReadData = {r_overflow, w_full, w_empty, 13'b0, 16'(r_count)};
            default:    ReadData = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_arm_data_mem_bridge.sv
module tb_arm_data_mem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        vram_valid;
    logic        vram_ready;
    logic [18:0] vram_addr;
    logic [31:0] vram_data;

    arm_data_mem_bridge dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .vram_valid(vram_valid),
        .vram_ready(vram_ready), .vram_addr(vram_addr), .vram_data(vram_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        chk;
    } vec_t;

    typedef struct {
        logic [18:0] a;
        logic [31:0] d;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_pops   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = we;
        ALUResult = a;
        WriteData = d;
    endtask

    // Each handshake seen mid-cycle is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && vram_valid && vram_ready) begin
            n_pops++;
            if (sb_q.size() == 0) begin
                chk("drain_unexpected", 32'(vram_addr), 32'hFFFF_FFFF);
            end else begin
                chk("drain_addr", 32'(vram_addr), 32'(sb_q[0].a));
                chk("drain_data", vram_data, sb_q[0].d);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'h0000_002A, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_002A, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_0108, 32'h0,         32'h0000_002A, 1'b1};
        vecs[3]  = '{1'b0, 32'h3000_0000, 32'h0,         32'h0, 1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_1111, 1'b1};
        vecs[7]  = '{1'b0, 32'h1000_0000, 32'h0,         32'h0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_00FC, 32'h1234_5678, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_01FE, 32'h0,         32'h1234_5678, 1'b1};
        vecs[10] = '{1'b0, 32'h2000_0044, 32'h0,         32'h2000_0000, 1'b1};
        vecs[11] = '{1'b0, 32'hF000_0008, 32'h0,         32'h0, 1'b1};

        reset = 1'b1;
        vram_ready = 1'b0;
        drive(1'b0, 32'h2000_0000, 32'h0);
        #1;
        chk("reset_status", ReadData, 32'h2000_0000);
        chk("reset_valid", 32'(vram_valid), 32'h0);
        chk("reset_addr", 32'(vram_addr), 32'h0);
        chk("reset_data", vram_data, 32'h0);
        #11 reset = 1'b0;
        tick();

        // RAM, aliasing and the unmapped regions.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            if (vecs[i].chk) chk($sformatf("vec%0d", i), ReadData, vecs[i].exp);
            tick();
        end
        drive(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        tick();

        // A single VRAM store held under backpressure, then released.
        drive(1'b1, 32'h1000_0010, 32'hFF00_FF00);
        sb_q.push_back('{19'd4, 32'hFF00_FF00});
        #1;
        chk("no_bypass", 32'(vram_valid), 32'h0);
        tick();
        drive(1'b0, 32'h1000_0000, 32'h0);
        chk("vram_load_zero", ReadData, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(vram_valid), 32'h1);
            chk("hold_addr", 32'(vram_addr), 32'h4);
            chk("hold_data", vram_data, 32'hFF00_FF00);
            tick();
        end
        vram_ready = 1'b1;
        tick();
        vram_ready = 1'b0;
        chk("single_drained", 32'(vram_valid), 32'h0);

        // Nine stores into an eight-entry FIFO: the ninth is dropped.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h1000_0000 + 32'(4 * i), 32'hA0 + 32'(i));
            if (i < 8) sb_q.push_back('{19'(i), 32'hA0 + 32'(i)});
            tick();
        end
        drive(1'b0, 32'h2000_0000, 32'h0);
        #1;
        chk("status_overflow", ReadData, 32'hC000_0008);
        drive(1'b1, 32'h2000_0010, 32'h8000_0000);
        tick();
        drive(1'b0, 32'h2000_0000, 32'h0);
        #1;
        chk("status_cleared", ReadData, 32'h4000_0008);

        // Full FIFO with a store and a pop on the same edge.
        drive(1'b1, 32'h1000_0100, 32'h0000_00B0);
        vram_ready = 1'b1;
        sb_q.push_back('{19'h40, 32'h0000_00B0});
        tick();
        vram_ready = 1'b0;
        drive(1'b0, 32'h2000_0000, 32'h0);
        #1;
        chk("full_push_pop", ReadData, 32'h4000_0008);

        // Drain everything. The scoreboard order shows that 0xA8 never appears.
        vram_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        vram_ready = 1'b0;
        #1;
        chk("status_drained", ReadData, 32'h2000_0000);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        chk("pop_count", 32'(n_pops), 32'd10);

        // Asynchronous reset off the clock edge while four entries are queued.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000_0000 + 32'(4 * i), 32'hC0 + 32'(i));
            tick();
        end
        drive(1'b0, 32'h2000_0000, 32'h0);
        #1;
        chk("pre_reset_status", ReadData, 32'h0000_0004);
        #1;
        reset = 1'b1;
        vram_ready = 1'b1;
        #1;
        chk("async_valid", 32'(vram_valid), 32'h0);
        chk("async_addr", 32'(vram_addr), 32'h0);
        chk("async_status", ReadData, 32'h2000_0000);
        #2;
        reset = 1'b0;
        sb_q.delete();
        tick();
        vram_ready = 1'b0;
        chk("post_reset_valid", 32'(vram_valid), 32'h0);
        chk("post_reset_status", ReadData, 32'h2000_0000);
        drive(1'b0, 32'h0000_0020, 32'h0);
        #1;
        chk("ram_survives", ReadData, 32'hCAFE_F00D);
        chk("no_pop_in_reset", 32'(n_pops), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
